// File: rtl/layer2_reader_pkg.sv
// layer2_reader_pkg
// Shared types and defaults for the layer-2 result window reader:
//   - L2_MAP_H / L2_MAP_W : default feature-map geometry (14x14)
//   - L2_DATA_W           : result word width (LAYER2_OUTPUT_LENGTH)
//   - rd_state_e          : sequencer FSM states
//   - rd_entry_t          : one buffered result word with its coordinates
//   - ENTRY_W             : flattened width of rd_entry_t for plain-vector ports
package layer2_reader_pkg;

    localparam int L2_MAP_H  = 14;
    localparam int L2_MAP_W  = 14;
    localparam int L2_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

    typedef struct packed {
        logic [L2_DATA_W-1:0] data;
        logic [7:0]           row;
        logic [7:0]           col;
        logic                 last;
        logic                 pad;
    } rd_entry_t;

    localparam int ENTRY_W = $bits(rd_entry_t);

endpackage

// File: rtl/layer2_reader_fifo2.sv
// layer2_reader_fifo2
// Two-entry first-word-fall-through buffer for reader entries.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears storage too,
//                so the head reads as all-zero after reset)
//   push       : write push_entry this edge (caller guarantees not full)
//   push_entry : entry to store
//   pop        : retire the head this edge (caller guarantees not empty)
//   head       : oldest stored entry, valid whenever count != 0
//   count      : number of stored entries (0..2)
module layer2_reader_fifo2
    import layer2_reader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head,
    output logic [1:0]         count
);

    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/layer2_result_window_reader.sv
// layer2_result_window_reader
// Scans the layer-2 feature map in row-major order, drives the result store's
// read address/enable, absorbs the store's one-cycle read latency through a
// single in-flight stage, and streams words to layer 3 over valid/ready.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   start                      : begin a frame scan (ignored unless idle)
//   busy, done                 : scan active / one-cycle end-of-frame pulse
//   read_row_addr/col_addr     : store read address
//   layer2_result_read_signal  : store read enable and output gate
//   layer2_result_output       : store read data (one cycle after address)
//   out_valid/out_ready        : downstream handshake
//   out_data/row/col/last      : payload from the FIFO head
// Build option: define LAYER2_READER_ZERO_PAD_EN to scan a one-word zero border
// around the map ((MAP_H+2)x(MAP_W+2) frame); border words never touch the store.
module layer2_result_window_reader
    import layer2_reader_pkg::*;
#(
    parameter int MAP_H  = L2_MAP_H,
    parameter int MAP_W  = L2_MAP_W,
    parameter int DATA_W = L2_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       read_row_addr,
    output logic [15:0]       read_col_addr,
    output logic              layer2_result_read_signal,
    input  logic [DATA_W-1:0] layer2_result_output,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last
);

`ifdef LAYER2_READER_ZERO_PAD_EN
    localparam int SCAN_H = MAP_H + 2;
    localparam int SCAN_W = MAP_W + 2;
`else
    localparam int SCAN_H = MAP_H;
    localparam int SCAN_W = MAP_W;
`endif
    localparam logic [7:0] ROW_END = 8'(SCAN_H - 1);
    localparam logic [7:0] COL_END = 8'(SCAN_W - 1);

    rd_state_e state, state_nxt;

    logic [7:0] row, col;
    logic       last_pos;
    logic       border;
    logic       issue;
    logic       pop;
    logic [2:0] occ;

    // in-flight stage: the read whose data the store presents this cycle
    logic       if_vld;
    logic [7:0] if_row, if_col;
    logic       if_last, if_pad;

    rd_entry_t          push_entry;
    rd_entry_t          head;
    logic [ENTRY_W-1:0] head_w;
    logic [1:0]         fifo_count;

    assign last_pos = (row == ROW_END) && (col == COL_END);
    assign pop      = out_valid & out_ready;

    // Words already committed after this edge; issuing keeps FIFO + in-flight <= 2.
    assign occ   = {1'b0, fifo_count} + {2'b0, if_vld};
    assign issue = (state == ST_ISSUE) && (occ < (3'd2 + {2'b0, pop}));

`ifdef LAYER2_READER_ZERO_PAD_EN
    logic [15:0] hold_row, hold_col;

    assign border = (row == 8'd0) || (row == ROW_END) ||
                    (col == 8'd0) || (col == COL_END);

    // Border positions keep the last real address on the bus.
    always_comb begin
        read_row_addr = hold_row;
        read_col_addr = hold_col;
        if (!border) begin
            read_row_addr = {8'd0, row - 8'd1};
            read_col_addr = {8'd0, col - 8'd1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_row <= 16'd0;
            hold_col <= 16'd0;
        end else begin
            hold_row <= read_row_addr;
            hold_col <= read_col_addr;
        end
    end
`else
    assign border        = 1'b0;
    assign read_row_addr = {8'd0, row};
    assign read_col_addr = {8'd0, col};
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_ISSUE;
            ST_ISSUE: if (issue && last_pos) state_nxt = ST_DRAIN;
            // the final word is the only one left once it pops
            ST_DRAIN: if (pop && head.last && fifo_count == 2'd1 && !if_vld)
                          state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == ST_ISSUE) || (state == ST_DRAIN);
        done = (state == ST_DONE);
        layer2_result_read_signal = busy;
    end

    // scan counters and in-flight stage
    always_ff @(posedge clk) begin
        if (rst) begin
            row     <= 8'd0;
            col     <= 8'd0;
            if_vld  <= 1'b0;
            if_row  <= 8'd0;
            if_col  <= 8'd0;
            if_last <= 1'b0;
            if_pad  <= 1'b0;
        end else begin
            if_vld <= issue;
            if (issue) begin
                if_row  <= row;
                if_col  <= col;
                if_last <= last_pos;
                if_pad  <= border;
                if (col == COL_END) begin
                    col <= 8'd0;
                    row <= last_pos ? 8'd0 : row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

    always_comb begin
        push_entry.data = if_pad ? '0 : layer2_result_output;
        push_entry.row  = if_row;
        push_entry.col  = if_col;
        push_entry.last = if_last;
        push_entry.pad  = if_pad;
    end

    layer2_reader_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (if_vld),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head_w),
        .count      (fifo_count)
    );

    assign head      = head_w;
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head.pad ? '0 : head.data;
    assign out_row   = head.row;
    assign out_col   = head.col;
    assign out_last  = out_valid & head.last;

endmodule

// File: tb/tb_layer2_result_window_reader.sv
// Bench for layer2_result_window_reader: behavioural store model plus a
// row-major reference of the expected word stream, exercised with full-rate,
// random-backpressure, long-stall, mid-frame start and mid-frame reset frames.
module tb_layer2_result_window_reader;

    localparam int MAP_H  = 14;
    localparam int MAP_W  = 14;
    localparam int DATA_W = 128;
`ifdef LAYER2_READER_ZERO_PAD_EN
    localparam int SCAN_H = MAP_H + 2;
    localparam int SCAN_W = MAP_W + 2;
`else
    localparam int SCAN_H = MAP_H;
    localparam int SCAN_W = MAP_W;
`endif
    localparam int NWORDS = SCAN_H * SCAN_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done;
    logic [15:0]       read_row_addr, read_col_addr;
    logic              layer2_result_read_signal;
    logic [DATA_W-1:0] layer2_result_output;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_row, out_col;
    logic              out_last;

    int passed = 0;
    int total  = 0;
    logic [95:0] seed = '0;

    always #5 clk = ~clk;

    layer2_result_window_reader #(
        .MAP_H(MAP_H), .MAP_W(MAP_W), .DATA_W(DATA_W)
    ) dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .busy                      (busy),
        .done                      (done),
        .read_row_addr             (read_row_addr),
        .read_col_addr             (read_col_addr),
        .layer2_result_read_signal (layer2_result_read_signal),
        .layer2_result_output      (layer2_result_output),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_data                  (out_data),
        .out_row                   (out_row),
        .out_col                   (out_col),
        .out_last                  (out_last)
    );

    // store content: random tag per frame, then {row, col}
    function automatic logic [DATA_W-1:0] store_word(input int r, input int c);
        return {seed, r[15:0], c[15:0]};
    endfunction

    // k-th word of the frame in row-major order
    function automatic logic [DATA_W-1:0] exp_word(input int k);
        int r = k / SCAN_W;
        int c = k % SCAN_W;
`ifdef LAYER2_READER_ZERO_PAD_EN
        if (r == 0 || r == SCAN_H - 1 || c == 0 || c == SCAN_W - 1) return '0;
        return store_word(r - 1, c - 1);
`else
        return store_word(r, c);
`endif
    endfunction

    // result store: registered read, output gated by the read signal
    logic [DATA_W-1:0] store_q = '0;
    always @(posedge clk) store_q <= store_word(int'(read_row_addr), int'(read_col_addr));
    assign layer2_result_output = layer2_result_read_signal ? store_q : '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   128'(busy), 128'(0));
        chk({tag, "_done"},   128'(done), 128'(0));
        chk({tag, "_valid"},  128'(out_valid), 128'(0));
        chk({tag, "_last"},   128'(out_last), 128'(0));
        chk({tag, "_rdsig"},  128'(layer2_result_read_signal), 128'(0));
        chk({tag, "_rrow"},   128'(read_row_addr), 128'(0));
        chk({tag, "_rcol"},   128'(read_col_addr), 128'(0));
        chk({tag, "_orow"},   128'(out_row), 128'(0));
        chk({tag, "_ocol"},   128'(out_col), 128'(0));
        chk({tag, "_odata"},  128'(out_data), 128'(0));
    endtask

    // mode 0: ready high; 1: random ready + start re-pulse; 2: 20-cycle stall
    // rst_word > 0: assert reset right after that many words were accepted
    task automatic run_frame(input int mode, input int rst_word);
        int k = 0;
        int ei = 0;
        int first_v = -1;
        int done_e = -1;
        int stall = 0;
        int idx;
        logic v, rdy, pl;
        logic [DATA_W-1:0] pd;
        logic [7:0] pr, pc;

        seed = {$urandom, $urandom, $urandom};
        out_ready = (mode != 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_busy", 128'(busy), 128'(1));
        chk("start_rdsig", 128'(layer2_result_read_signal), 128'(1));
        chk("start_rrow", 128'(read_row_addr), 128'(0));
        chk("start_rcol", 128'(read_col_addr), 128'(0));

        while (done_e < 0 && ei < 4000) begin
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (stall >= 20);
                default: out_ready = 1'b1;
            endcase
            start = (mode == 1 && ei == 40);
            v = out_valid; rdy = out_ready;
            pd = out_data; pr = out_row; pc = out_col; pl = out_last;
            @(posedge clk); #1;
            ei++;
            start = 1'b0;
            if (v && rdy) begin
                chk("word_data", 128'(pd), 128'(exp_word(k)));
                chk("word_row", 128'(pr), 128'(k / SCAN_W));
                chk("word_col", 128'(pc), 128'(k % SCAN_W));
                chk("word_last", 128'(pl), 128'(k == NWORDS - 1));
                k++;
                if (k == rst_word) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    chk_reset("mid_rst");
                    return;
                end
            end else if (v) begin
                chk("hold_valid", 128'(out_valid), 128'(1));
                chk("hold_data", 128'(out_data), 128'(pd));
                chk("hold_row", 128'(out_row), 128'(pr));
                chk("hold_col", 128'(out_col), 128'(pc));
                chk("hold_last", 128'(out_last), 128'(pl));
            end
`ifndef LAYER2_READER_ZERO_PAD_EN
            // presented address index = reads issued; at most 2 words ahead of accepted
            if (mode == 1 && busy) begin
                idx = int'(read_row_addr) * MAP_W + int'(read_col_addr);
                chk("occupancy", 128'(idx <= k + 2), 128'(1));
            end
`endif
            if (out_valid && first_v < 0) first_v = ei;
            if (mode == 2 && first_v >= 0 && stall < 20) begin
                stall++;
                if (stall == 20) begin
                    chk("stall_rrow", 128'(read_row_addr), 128'(0));
`ifdef LAYER2_READER_ZERO_PAD_EN
                    chk("stall_rcol", 128'(read_col_addr), 128'(0));
`else
                    chk("stall_rcol", 128'(read_col_addr), 128'(2));
`endif
                    chk("stall_valid", 128'(out_valid), 128'(1));
                    chk("stall_head", 128'(out_col), 128'(0));
                end
            end
            if (done) done_e = ei;
        end

        chk("done_seen", 128'(done_e >= 0), 128'(1));
        chk("word_count", 128'(k), 128'(NWORDS));
        chk("first_valid_edge", 128'(first_v), 128'(2));
        if (mode == 0) chk("done_edge", 128'(done_e), 128'(NWORDS + 2));
        @(posedge clk); #1;
        chk("done_pulse", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_valid", 128'(out_valid), 128'(0));
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(0, 50);
        run_frame(0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
